// File: rtl/mfp_uart_transmitter.sv
// Byte-wide UART transmitter (8N1) with a small input FIFO.
// Define MFP_UART_TX_PARITY_EN to add an even-parity bit (8E1).
module mfp_uart_transmitter #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef MFP_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("mfp_uart_transmitter: CLK_HZ/BAUD must be >= 2");
    end
    if (FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mfp_uart_transmitter: FIFO_DEPTH must be 2^n, >= 2");
    end
  endgenerate

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_n;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bitcnt;
  logic [2:0]    bitcnt_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          tick;
  logic          tx_n;
`ifdef MFP_UART_TX_PARITY_EN
  logic          par_q;
  logic          par_n;
`endif

  assign push = tx_valid && tx_ready;
  assign head = mem[rptr];
  assign tick = (cnt == DIV_LAST);
  assign busy = (state != S_IDLE) || (count != '0);

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    pop      = 1'b0;
    cnt_n    = (state == S_IDLE || tick) ? '0 : cnt + 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
    par_n    = par_q;
`endif
    unique case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shreg_n = head;
          state_n = S_START;
`ifdef MFP_UART_TX_PARITY_EN
          par_n   = ^head;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          bitcnt_n = '0;
          state_n  = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_n  = {1'b0, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef MFP_UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) begin
          // chain straight into the next start bit when more data waits
          if (count != '0) begin
            pop     = 1'b1;
            shreg_n = head;
            state_n = S_START;
`ifdef MFP_UART_TX_PARITY_EN
            par_n   = ^head;
`endif
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shreg_n[0];
`ifdef MFP_UART_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
`ifdef MFP_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bitcnt   <= bitcnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      tx_ready <= (count_n != FULL_CNT);
      count    <= count_n;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Directed bench for mfp_uart_transmitter (DIV=10, depth 4).
// Honours MFP_UART_TX_PARITY_EN for frame layout and length.
module tb_mfp_uart_transmitter;

  localparam int DIV = 10;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int n_chk;
  int n_err;
  int cyc;

  mfp_uart_transmitter #(
    .CLK_HZ(1000000),
    .BAUD(100000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge just before the start-bit edge.
  task automatic check_frame(input logic [7:0] b);
    logic [10:0] bits;
    logic [9:0]  v;
`ifdef MFP_UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, 1'b1, b, 1'b0};
`endif
    for (int k = 0; k < NBITS; k++) begin
      v = '0;
      repeat (DIV) begin
        @(negedge clk);
        v = {v[8:0], tx};
      end
      chk($sformatf("frm%02h_bit%0d", b, k), {22'd0, v},
          bits[k] ? 32'h3FF : 32'h0);
    end
  endtask

  task automatic push_one(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    chk("push_ready", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, busy, 1'b0);
  endtask

  logic [7:0] wrap_vec [12];
  int acc [6];
  int stalls;
  int bad;

  initial begin
    wrap_vec = '{8'hA5, 8'h3C, 8'hF0, 8'h0F,
                 8'h81, 8'h7E, 8'hC3, 8'h99,
                 8'h12, 8'h34, 8'h56, 8'h78};
    n_chk    = 0;
    n_err    = 0;
    cyc      = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // reset held from time zero
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", tx_ready, 1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // reset again while idle
    #2 reset = 1'b1;
    #1 chk("rst_idle_tx", tx, 1'b1);
    chk("rst_idle_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset in the middle of a frame of zeros
    push_one(8'h00);
    repeat (34) @(negedge clk);
    chk("mid_tx_low", tx, 1'b0);
    chk("mid_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1 chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", tx_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (!tx || busy) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    // single byte with one-cycle latency
    push_one(8'h55);
    chk("lat_tx_high", tx, 1'b1);
    chk("lat_busy", busy, 1'b1);
    check_frame(8'h55);
    chk("end_busy_hi", busy, 1'b1);
    @(negedge clk);
    chk("end_busy_lo", busy, 1'b0);
    chk("end_tx", tx, 1'b1);

    // burst of 6 with stalled, changing data on the last one
    repeat (5) @(negedge clk);
    stalls = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int k;
          k = 0;
          while (!tx_ready && k < 400) begin
            tx_data  = 8'hE0 + 8'(k);
            tx_valid = 1'b1;
            @(negedge clk);
            k++;
            stalls++;
          end
          chk($sformatf("burst_to%0d", i), (k >= 400), 1'b0);
          tx_data  = 8'(i);
          tx_valid = 1'b1;
          @(negedge clk);
          acc[i] = cyc;
        end
        tx_valid = 1'b0;
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 6; i++) check_frame(8'(i));
      end
    join
    for (int i = 1; i < 5; i++)
      chk($sformatf("burst_acc%0d", i), acc[i] - acc[0], i);
    chk("burst_acc5", acc[5] - acc[0], FRAME + 2);
    chk("burst_stalls", stalls, FRAME - 3);
    @(negedge clk);
    chk("burst_idle", busy, 1'b0);
    chk("burst_ready", tx_ready, 1'b1);

    // wrap-around: three bursts of four with gaps
    for (int g = 0; g < 3; g++) begin
      repeat (7) @(negedge clk);
      fork
        begin
          for (int i = 0; i < 4; i++) begin
            tx_data  = wrap_vec[g*4 + i];
            tx_valid = 1'b1;
            chk("wrap_ready", tx_ready, 1'b1);
            @(negedge clk);
          end
          tx_valid = 1'b0;
        end
        begin
          @(negedge clk);
          for (int i = 0; i < 4; i++) check_frame(wrap_vec[g*4 + i]);
        end
      join
      wait_idle($sformatf("wrap_idle%0d", g));
    end

    // parity-sensitive patterns and full-frame length
    repeat (4) @(negedge clk);
    push_one(8'h07);
    check_frame(8'h07);
    @(negedge clk);
    chk("len07_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    push_one(8'h03);
    check_frame(8'h03);
    @(negedge clk);
    chk("len03_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
